mem_port_arbiter: RTL and testbench

- Shares the single memory port between two requesters: instruction fetch (port 0) and load/store (port 1).
- Sequences each transaction through a grant/response FSM.
- Drives the select of the 32-bit 2:1 address/data mux in front of the memory. `sel`=0 passes requester 0 (in1); `sel`=1 passes requester 1 (in2).
- Uses round-robin fairness, so neither port starves.

---
 rtl/mem_port_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port between fetch (0) and load/store (1).
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          req0_valid,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req0_we,
  output logic          req0_ready,
  output logic [DW-1:0] req0_rdata,

  input  logic          req1_valid,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  input  logic          req1_we,
  output logic          req1_ready,
  output logic [DW-1:0] req1_rdata,

  output logic          mem_valid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,

  output logic          sel,
  output logic          busy,
  output logic          timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT0,
    S_GRANT1,
    S_RESP
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic          r_sel;
  logic          r_last;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_we;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic          w_pick;
  logic          w_gport;
  logic          w_grant;
  logic          w_done;
  logic          w_abort;
  logic          w_tmo_hit;
  logic [DW-1:0] w_rdata;

  // Arbitration: a lone requester wins; a tie goes to the port that did not win last.
  always_comb begin
    w_pick  = 1'b0;
    w_gport = 1'b0;
    unique case (1'b1)
      (req0_valid & req1_valid): begin
        w_pick  = 1'b1;
        w_gport = ~r_last;
      end
      (req0_valid & ~req1_valid): begin
        w_pick  = 1'b1;
        w_gport = 1'b0;
      end
      (~req0_valid & req1_valid): begin
        w_pick  = 1'b1;
        w_gport = 1'b1;
      end
      default: begin
        w_pick  = 1'b0;
        w_gport = 1'b0;
      end
    endcase
  end

  // State register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus the state-decoded handshake outputs.
  always_comb begin
    w_next     = r_state;
    w_grant    = 1'b0;
    w_done     = 1'b0;
    w_abort    = 1'b0;
    mem_valid  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    busy       = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_pick) begin
          w_grant = 1'b1;
          w_next  = w_gport ? S_GRANT1 : S_GRANT0;
        end
      end
      S_GRANT0, S_GRANT1: begin
        mem_valid = 1'b1;
        if (mem_ready) begin
          w_done = 1'b1;
          w_next = S_RESP;
        end else if (w_tmo_hit) begin
          w_abort = 1'b1;
          w_next  = S_RESP;
        end
      end
      S_RESP: begin
        req0_ready = ~r_sel;
        req1_ready = r_sel;
        w_next     = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] r_tmo_cnt;
  logic          r_tmo_err;
  logic          w_in_grant;

  assign w_in_grant = (r_state == S_GRANT0) || (r_state == S_GRANT1);
  assign w_tmo_hit  = (r_tmo_cnt == CW'(TIMEOUT - 1));

  // Watchdog: restarts on each grant, counts grant cycles the memory leaves unanswered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (w_grant) begin
      r_tmo_cnt <= '0;
    end else if (w_in_grant && !mem_ready) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Error flag covers exactly the RESP cycle that follows an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_err <= 1'b0;
    end else begin
      r_tmo_err <= w_abort;
    end
  end

  assign timeout_err = r_tmo_err;
`else
  // No watchdog: a grant waits for the memory indefinitely.
  assign w_tmo_hit   = (TIMEOUT < 0);
  assign timeout_err = 1'b0;
`endif

  // Latch the winner's request; requester inputs are ignored until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_addr  <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else if (w_grant) begin
      r_sel   <= w_gport;
      r_last  <= w_gport;
      r_addr  <= w_gport ? req1_addr  : req0_addr;
      r_wdata <= w_gport ? req1_wdata : req0_wdata;
      r_we    <= w_gport ? req1_we    : req0_we;
    end
  end

  // An aborted grant returns zero instead of whatever sits on the bus.
  assign w_rdata = w_abort ? '0 : mem_rdata;

  // Return data holds per port until that port's next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (w_done || w_abort) begin
      if (r_sel) begin
        r_rdata1 <= w_rdata;
      end else begin
        r_rdata0 <= w_rdata;
      end
    end
  end

  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_we     = r_we;
  assign sel        = r_sel;
  assign req0_rdata = r_rdata0;
  assign req1_rdata = r_rdata1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios, then random traffic
// against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req0_we, req0_ready;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, req0_rdata;
  logic          req1_valid, req1_we, req1_ready;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, req1_rdata;
  logic          mem_valid, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          sel, busy, timeout_err;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_we(req0_we),
    .req0_ready(req0_ready), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_we(req1_we),
    .req1_ready(req1_ready), .req1_rdata(req1_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .sel(sel), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: one outstanding transaction at a time
  int          mph;    // 0 free, 1 memory access, 2 completion cycle
  bit          mport, mlast, msel, merr;
  int          mwait;
  logic [31:0] mrd [2];
  logic [31:0] maddr, mwd;
  bit          mwe;

  // requester drivers
  bit          rv  [2];
  logic [31:0] ra  [2];
  logic [31:0] rw  [2];
  bit          rwe [2];

  task automatic model_reset();
    mph = 0; mport = 0; mlast = 1; msel = 0; merr = 0; mwait = 0;
    mrd[0] = '0; mrd[1] = '0; maddr = '0; mwd = '0; mwe = 0;
  endtask

  // advance the model by the clock edge that just passed
  task automatic model_step();
    if (mph == 2) begin
      mph = 0; merr = 0;
    end else if (mph == 1) begin
      if (mem_ready) begin
        mrd[mport] = mem_rdata; mph = 2;
      end else begin
        mwait++;
`ifdef ARB_TIMEOUT_EN
        if (mwait >= TMO) begin
          mrd[mport] = '0; merr = 1; mph = 2;
        end
`endif
      end
    end else if (req0_valid || req1_valid) begin
      if (req0_valid && req1_valid) mport = !mlast;
      else mport = req1_valid;
      mlast = mport; msel = mport; mwait = 0; mph = 1;
      maddr = mport ? req1_addr  : req0_addr;
      mwd   = mport ? req1_wdata : req0_wdata;
      mwe   = mport ? req1_we    : req0_we;
    end
  endtask

  task automatic model_check();
    chk1("r_mem_valid", mem_valid, mph == 1);
    chk1("r_busy", busy, mph != 0);
    chk1("r_sel", sel, msel);
    chk1("r_ready0", req0_ready, mph == 2 && mport == 0);
    chk1("r_ready1", req1_ready, mph == 2 && mport == 1);
    chk1("r_tmo_err", timeout_err, mph == 2 && merr);
    chk32("r_rdata0", req0_rdata, mrd[0]);
    chk32("r_rdata1", req1_rdata, mrd[1]);
    if (mph == 1) begin
      chk32("r_mem_addr", mem_addr, maddr);
      chk32("r_mem_wdata", mem_wdata, mwd);
      chk1("r_mem_we", mem_we, mwe);
    end
  endtask

  task automatic drive_random();
    for (int n = 0; n < 2; n++) begin
      bit mine;
      mine = (mph != 0) && (mport == 1'(n));
      if (rv[n]) begin
        if (mine && mph == 2) begin
          if ($urandom_range(3) == 0) begin
            ra[n] = $urandom; rw[n] = $urandom; rwe[n] = 1'($urandom_range(1));
          end else begin
            rv[n] = 0;
          end
        end else if (mine) begin
          ra[n] = $urandom; rw[n] = $urandom; rwe[n] = 1'($urandom_range(1));
        end else if ($urandom_range(15) == 0) begin
          rv[n] = 0;
        end
      end else if ($urandom_range(2) == 0) begin
        rv[n] = 1;
        ra[n] = $urandom; rw[n] = $urandom; rwe[n] = 1'($urandom_range(1));
      end
    end
    req0_valid = rv[0]; req0_addr = ra[0]; req0_wdata = rw[0]; req0_we = rwe[0];
    req1_valid = rv[1]; req1_addr = ra[1]; req1_wdata = rw[1]; req1_we = rwe[1];
    mem_ready = 1'($urandom_range(1));
    mem_rdata = $urandom;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_addr = '0; req0_wdata = '0; req0_we = 0;
    req1_valid = 0; req1_addr = '0; req1_wdata = '0; req1_we = 0;
    mem_ready = 0; mem_rdata = '0;
    for (int n = 0; n < 2; n++) begin
      rv[n] = 0; ra[n] = '0; rw[n] = '0; rwe[n] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_rdy, seen_err, mv_ok;
    rst_n = 0;
    idle_inputs();
    model_reset();

    // reset values
    @(negedge clk);
    @(negedge clk);
    chk1("rst_mem_valid", mem_valid, 1'b0);
    chk1("rst_sel", sel, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready0", req0_ready, 1'b0);
    chk1("rst_ready1", req1_ready, 1'b0);
    chk32("rst_rdata0", req0_rdata, 32'h0);
    chk32("rst_rdata1", req1_rdata, 32'h0);
    chk1("rst_tmo_err", timeout_err, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk1("rst_mem_we", mem_we, 1'b0);
    rst_n = 1;

    // single fetch, zero-wait memory
    req0_valid = 1; req0_addr = 32'h100;
    mem_ready = 1; mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk1("f_mem_valid", mem_valid, 1'b1);
    chk32("f_mem_addr", mem_addr, 32'h100);
    chk1("f_sel", sel, 1'b0);
    chk1("f_ready_early", req0_ready, 1'b0);
    @(negedge clk);
    chk1("f_ready", req0_ready, 1'b1);
    chk1("f_ready1", req1_ready, 1'b0);
    chk32("f_rdata", req0_rdata, 32'hDEADBEEF);
    chk1("f_mem_valid_off", mem_valid, 1'b0);
    req0_valid = 0; mem_ready = 0;
    @(negedge clk);
    chk1("f_ready_once", req0_ready, 1'b0);
    chk1("f_busy_idle", busy, 1'b0);
    chk32("f_rdata_hold", req0_rdata, 32'hDEADBEEF);

    // contention from reset: 0,1,0,1
    do_reset();
    req0_valid = 1; req0_addr = 32'h10;
    req1_valid = 1; req1_addr = 32'h20;
    mem_ready = 1;
    for (int i = 0; i < 4; i++) begin
      bit p;
      p = 1'(i % 2);
      mem_rdata = 32'hA0 + 32'(i);
      @(negedge clk);
      chk1("c_mem_valid", mem_valid, 1'b1);
      chk1("c_sel", sel, p);
      chk32("c_mem_addr", mem_addr, p ? 32'h20 : 32'h10);
      @(negedge clk);
      chk1("c_ready0", req0_ready, !p);
      chk1("c_ready1", req1_ready, p);
      chk32("c_rdata", p ? req1_rdata : req0_rdata, 32'hA0 + 32'(i));
      @(negedge clk);
      chk1("c_busy_idle", busy, 1'b0);
    end
    req0_valid = 0; req1_valid = 0; mem_ready = 0;

    // store on port 1 with four wait states and inputs changing mid-grant
    @(negedge clk);
    req1_valid = 1; req1_we = 1; req1_wdata = 32'h55; req1_addr = 32'h200;
    mem_rdata = 32'hCAFE0001;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk1("w_mem_valid", mem_valid, 1'b1);
      chk32("w_mem_addr", mem_addr, 32'h200);
      chk1("w_mem_we", mem_we, 1'b1);
      chk32("w_mem_wdata", mem_wdata, 32'h55);
      chk1("w_sel", sel, 1'b1);
      chk1("w_ready_early", req1_ready, 1'b0);
      if (k == 2) begin
        req1_addr = 32'h999; req1_wdata = 32'h77; req1_we = 0;
      end
      if (k == 5) mem_ready = 1;
    end
    @(negedge clk);
    chk1("w_ready", req1_ready, 1'b1);
    chk32("w_rdata", req1_rdata, 32'hCAFE0001);
    chk1("w_mem_valid_off", mem_valid, 1'b0);
    req1_valid = 0; req1_we = 0; mem_ready = 0;
    @(negedge clk);
    chk1("w_ready_once", req1_ready, 1'b0);
    chk1("w_busy_idle", busy, 1'b0);

    // asynchronous reset in the middle of a port 1 grant
    req1_valid = 1; req1_addr = 32'h300;
    @(negedge clk);
    chk1("r_pre_sel", sel, 1'b1);
    chk1("r_pre_busy", busy, 1'b1);
    #2 rst_n = 0;
    #1;
    chk1("ar_mem_valid", mem_valid, 1'b0);
    chk1("ar_busy", busy, 1'b0);
    chk1("ar_sel", sel, 1'b0);
    chk1("ar_ready1", req1_ready, 1'b0);
    req1_valid = 0;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("ar_no_ready", req1_ready, 1'b0);
      chk1("ar_idle", busy, 1'b0);
    end
    req0_valid = 1; req0_addr = 32'h40;
    req1_valid = 1; req1_addr = 32'h50;
    mem_ready = 1; mem_rdata = 32'h12345678;
    @(negedge clk);
    chk1("ar_prio_sel", sel, 1'b0);
    chk32("ar_prio_addr", mem_addr, 32'h40);
    @(negedge clk);
    chk1("ar_prio_ready", req0_ready, 1'b1);
    chk32("ar_prio_rdata", req0_rdata, 32'h12345678);
    req0_valid = 0; req1_valid = 0; mem_ready = 0;
    @(negedge clk);
    chk1("ar_busy_after", busy, 1'b0);

    // memory that never answers
    req0_valid = 1; req0_addr = 32'h60;
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      chk1("t_mem_valid", mem_valid, 1'b1);
      chk1("t_ready_early", req0_ready, 1'b0);
      chk1("t_err_early", timeout_err, 1'b0);
    end
    @(negedge clk);
    chk1("t_ready", req0_ready, 1'b1);
    chk1("t_err", timeout_err, 1'b1);
    chk32("t_rdata_zero", req0_rdata, 32'h0);
    chk1("t_mem_valid_off", mem_valid, 1'b0);
    req0_valid = 0;
    @(negedge clk);
    chk1("t_err_once", timeout_err, 1'b0);
    chk1("t_busy_idle", busy, 1'b0);
    // ready on the limit cycle completes normally
    req1_valid = 1; req1_addr = 32'h70; mem_rdata = 32'hBEEF0070;
    for (int k = 1; k <= TMO; k++) begin
      @(negedge clk);
      if (k == TMO) mem_ready = 1;
    end
    @(negedge clk);
    chk1("tl_ready", req1_ready, 1'b1);
    chk1("tl_err", timeout_err, 1'b0);
    chk32("tl_rdata", req1_rdata, 32'hBEEF0070);
    req1_valid = 0; mem_ready = 0;
    @(negedge clk);
`else
    seen_rdy = 0; seen_err = 0; mv_ok = 1;
    repeat (100) begin
      @(negedge clk);
      if (req0_ready) seen_rdy = 1;
      if (timeout_err) seen_err = 1;
      if (!mem_valid) mv_ok = 0;
    end
    chk1("n_no_ready", seen_rdy, 1'b0);
    chk1("n_no_err", seen_err, 1'b0);
    chk1("n_still_valid", mv_ok, 1'b1);
    mem_ready = 1; mem_rdata = 32'h600D;
    @(negedge clk);
    chk1("n_ready", req0_ready, 1'b1);
    chk32("n_rdata", req0_rdata, 32'h600D);
    req0_valid = 0; mem_ready = 0;
    @(negedge clk);
`endif

    // requester keeps valid one cycle past its ready pulse
    req0_valid = 1; req0_addr = 32'h80;
    mem_ready = 1; mem_rdata = 32'h0F0F;
    @(negedge clk);
    chk1("h_mem_valid", mem_valid, 1'b1);
    @(negedge clk);
    chk1("h_ready", req0_ready, 1'b1);
    mem_ready = 0;
    @(negedge clk);
    chk1("h_busy", busy, 1'b0);
    chk1("h_no_regrant", mem_valid, 1'b0);
    chk1("h_ready_once", req0_ready, 1'b0);
    req0_valid = 0;
    @(negedge clk);
    chk1("h_busy2", busy, 1'b0);
    chk1("h_no_grant2", mem_valid, 1'b0);

    // random traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      model_step();
      model_check();
      drive_random();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
